// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divider FSM state encoding and iteration/latency constants.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int MDU_DIV_ITER    = 32;
    localparam int MDU_DIV_LATENCY = 34;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign correction of the raw unsigned quotient/remainder for DIV.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] quo_raw,
    input  logic [WIDTH-1:0] rem_raw,
    input  logic             sign,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);

    logic neg_quo;
    logic neg_rem;

    // Remainder follows the dividend's sign; quotient is negative when signs differ.
    assign neg_quo = sign & (a_msb ^ b_msb);
    assign neg_rem = sign & a_msb;

    assign lo_fix = neg_quo ? (~quo_raw + 1'b1) : quo_raw;
    assign hi_fix = neg_rem ? (~rem_raw + 1'b1) : rem_raw;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (MIPS DIV/DIVU): remainder on Hi, quotient on Lo.
// Optional SEQ_DIVIDER_EARLY_EXIT_EN skips the iterations for zero divisor or |a| < |b|.
module seq_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output div_state_t       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a request is captured in any IDLE cycle with validIn high; the
    // initiator holds validIn until it sees validOut, which pulses for one cycle in DONE.

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dmag;
    logic             sign_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic             div_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             early_exit;
    logic [WIDTH:0]   shifted;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    assign a_mag = (sign && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
    assign b_mag = (sign && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign early_exit = (b_mag == '0) || (a_mag < b_mag);
`else
    assign early_exit = 1'b0;
`endif

    // WIDTH+1-bit trial: the shifted-out top bit guarantees the subtraction fits.
    assign shifted    = {rem, quo[WIDTH-1]};
    assign trial_ge   = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dmag);
    assign trial_diff = shifted[WIDTH-1:0] - dmag;

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .quo_raw (quo),
        .rem_raw (rem),
        .sign    (sign_r),
        .a_msb   (a_msb_r),
        .b_msb   (b_msb_r),
        .hi_fix  (hi_fix),
        .lo_fix  (lo_fix)
    );

    always_comb begin
        state_next = state;
        validOut   = 1'b0;
        case (state)
            IDLE: if (validIn) state_next = early_exit ? FIX : BUSY;
            BUSY: if (cnt == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                validOut   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            sign_r   <= 1'b0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            div_zero <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (validIn) begin
                    sign_r   <= sign;
                    a_msb_r  <= SrcA[WIDTH-1];
                    b_msb_r  <= SrcB[WIDTH-1];
                    dmag     <= b_mag;
                    div_zero <= (b_mag == '0);
                    cnt      <= CW'(WIDTH - 1);
                    if (early_exit) begin
                        rem <= a_mag;
                        quo <= '0;
                    end else begin
                        rem <= '0;
                        quo <= a_mag;
                    end
                end
                BUSY: begin
                    rem <= trial_ge ? trial_diff : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ge};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    // Zero divisor: remainder path already yields the dividend; force quotient to all-ones.
                    Hi <= hi_fix;
                    Lo <= div_zero ? '1 : lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
